// File: rtl/wishbone_cmd_master.sv
// wishbone_cmd_master
//   Converts a valid/ready command stream into single classic-cycle Wishbone
//   transfers, one outstanding at a time. Each transfer produces one response
//   carrying read data, or an error when the slave never acknowledges within
//   TIMEOUT bus cycles. A saturating counter tracks how many timeouts occurred.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   req_valid/req_ready              command handshake
//   req_we, req_adr, req_dat         command: direction, address, write data
//   rsp_valid/rsp_ready              response handshake
//   rsp_dat, rsp_err                 read data (0 for writes/errors), timeout flag
//   err_cnt                          saturating timeout count since reset
//   adr_o/dat_o/we_o/cyc_o/stb_o     Wishbone initiator outputs (_master)
//   dat_i/ack_i                      Wishbone initiator inputs (_master)
module wishbone_cmd_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_adr,
  input  logic [DATA_WIDTH-1:0] req_dat,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_dat,
  output logic                  rsp_err,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] adr_o_master,
  output logic [DATA_WIDTH-1:0] dat_o_master,
  output logic                  we_o_master,
  output logic                  cyc_o_master,
  output logic                  stb_o_master,
  input  logic [DATA_WIDTH-1:0] dat_i_master,
  input  logic                  ack_i_master
);

  // Wide enough to hold TIMEOUT; a single bit when the timeout is disabled.
  localparam int unsigned TimerW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimeoutLast =
      (TIMEOUT == 0) ? '0 : TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  state_e            state;
  logic [TimerW-1:0] tcnt;
  logic              timeout_hit;

  assign req_ready   = (state == StIdle);
  // Disabled entirely when TIMEOUT is 0; the transfer then waits for ack forever.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TimeoutLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= StIdle;
      tcnt         <= '0;
      adr_o_master <= '0;
      dat_o_master <= '0;
      we_o_master  <= 1'b0;
      cyc_o_master <= 1'b0;
      stb_o_master <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_dat      <= '0;
      rsp_err      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            // Write data is latched for reads as well; slaves ignore it.
            adr_o_master <= req_adr;
            dat_o_master <= req_dat;
            we_o_master  <= req_we;
            cyc_o_master <= 1'b1;
            stb_o_master <= 1'b1;
            tcnt         <= '0;
            state        <= StBus;
          end
        end
        StBus: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (ack_i_master) begin
            cyc_o_master <= 1'b0;
            stb_o_master <= 1'b0;
            rsp_dat      <= we_o_master ? '0 : dat_i_master;
            rsp_err      <= 1'b0;
            rsp_valid    <= 1'b1;
            tcnt         <= '0;
            state        <= StResp;
          end else if (timeout_hit) begin
            cyc_o_master <= 1'b0;
            stb_o_master <= 1'b0;
            rsp_dat      <= '0;
            rsp_err      <= 1'b1;
            rsp_valid    <= 1'b1;
            tcnt         <= '0;
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
            state        <= StResp;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        StResp: begin
          // Late acks land here and are ignored.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/wishbone_cmd_master.md
Name: wishbone_cmd_master

Overview:
- Wishbone initiator: turns a simple valid/ready command stream into single classic-cycle Wishbone transfers.
- Drives the one_to_many_master side of the Wishbone bus interconnect.
- Exactly one transfer outstanding at a time.
- Returns read data or a timeout error on a valid/ready response stream, and keeps a saturating error count.

Parameters:
- DATA_WIDTH, 32, width of Wishbone data and command/response data.
- ADDR_WIDTH, 32, width of Wishbone address and command address.
- TIMEOUT, 16, number of BUS-state cycles without ack before the transfer is aborted with error; 0 disables the timeout.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid  in  1  command present.
- req_ready  out  1  block can accept a command.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  ADDR_WIDTH  transfer address.
- req_dat  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_dat  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  1 = transfer timed out.
- err_cnt  out  CNT_WIDTH  number of timeouts since reset, saturating.
- adr_o_master  out  ADDR_WIDTH  Wishbone address.
- dat_o_master  out  DATA_WIDTH  Wishbone write data.
- we_o_master  out  1  Wishbone write enable.
- cyc_o_master  out  1  Wishbone cycle.
- stb_o_master  out  1  Wishbone strobe.
- dat_i_master  in  DATA_WIDTH  Wishbone read data.
- ack_i_master  in  1  Wishbone acknowledge.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- All outputs are registered, except req_ready, which is decoded from state.
- Reset values: state IDLE, cyc/stb/we 0, adr_o/dat_o 0, rsp_valid 0, rsp_dat 0, rsp_err 0, err_cnt 0, timeout counter 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch req_adr/req_dat/req_we into adr_o/dat_o/we_o, set cyc=stb=1, clear the timeout counter, go to BUS.
  - dat_o is latched for reads too; slaves ignore it.
- BUS:
  - req_ready=0.
  - cyc, stb, adr, dat and we are held stable until the cycle ends.
  - ack_i_master=1 in any BUS cycle:
    - next edge: cyc=stb=0;
    - rsp_dat = we ? 0 : dat_i_master (sampled that cycle);
    - rsp_err=0, rsp_valid=1, go to RESP.
  - No ack: the timeout counter increments.
  - With TIMEOUT>0, if the counter equals TIMEOUT-1 and ack=0:
    - next edge: cyc=stb=0, rsp_dat=0, rsp_err=1, rsp_valid=1;
    - err_cnt increments unless all-ones;
    - go to RESP.
  - Ack in the same cycle as the timeout threshold: ack wins, no error.
  - TIMEOUT=0: waits forever.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready=1.
  - On rsp_ready: next edge rsp_valid=0, go to IDLE.
  - Back-pressure may last indefinitely.
- Latency:
  - Command accepted at edge N.
  - stb high in cycle N+1.
  - With zero-wait ack in N+1: rsp_valid high in cycle N+2.
  - With rsp_ready=1 in N+2: next command can be accepted at edge N+3.
  - Minimum issue interval is 3 cycles.
- ack_i_master is ignored in IDLE and RESP (late ack after a timeout has no effect).
- dat_i_master is only sampled on an accepted ack.
- Reset mid-transfer (BUS or RESP):
  - next edge returns everything to reset values; cyc/stb drop immediately;
  - the pending response is discarded;
  - err_cnt is cleared.
- Address/data width: passed through unmodified; no alignment checks; no select lines (full-word transfers only).
- The timeout counter is sized ceil(log2(TIMEOUT+1)), minimum 1 bit; it never wraps because it is cleared on leaving BUS.

Test Plan:
- Zero-wait write: req adr=0x2, dat=0xDEADBEEF, we=1; slave acks in first stb cycle -> stb high exactly 1 cycle with adr_o=0x2, dat_o=0xDEADBEEF, we=1; rsp_valid 2 cycles after accept, rsp_dat=0, rsp_err=0.
- Wait-state read: req adr=0x5, we=0; slave acks after 3 wait cycles with dat_i=0x12345678 -> stb high 4 cycles, adr stable throughout; rsp_dat=0x12345678, rsp_err=0.
- Timeout: TIMEOUT=16; slave never acks -> stb high exactly 16 cycles, then rsp_err=1, rsp_dat=0, err_cnt=1. A late ack 2 cycles later changes nothing. Ack arriving on cycle 16 -> no error.
- Back-pressure: rsp_ready held 0 for 10 cycles after a read -> rsp fields stable, req_ready=0, a pending req_valid is not accepted. rsp_ready=1 -> IDLE next cycle, command accepted the following edge.
- Back-to-back: 4 reads with req_valid=1 and rsp_ready=1 continuously, 0-wait ack -> accepts every 3 cycles, responses in order with correct data.
- Reset mid-BUS: rst_i asserted during the 2nd wait cycle -> cyc/stb 0 after the next edge, no rsp_valid, err_cnt=0; a new transfer after release completes normally. Separately, 260 timeouts with CNT_WIDTH=8 -> err_cnt saturates at 255.
